mips_muldiv_ctrl: RTL and testbench
===================================

Name: mips_muldiv_ctrl

Overview:
- Sequencing controller and iterative datapath for the MIPS HI/LO unit: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Sits beside the ALU in mips_cpu_harvard.
- The CPU issues an operation with a one-cycle start strobe and stalls on busy. MFHI/MFLO read hi/lo directly.
- Shift-add multiply and restoring divide, one bit per cycle, with a final sign-fix state.

Parameters:
DIV0_LO, 32'hFFFF_FFFF, value written to LO on divide by zero. HI receives the dividend.

Ports:
clk  input  1  system clock, rising edge
resetl  input  1  asynchronous reset, active-high
clk_enable  input  1  when low, all state, counters and registers hold
start  input  1  one-cycle strobe, begin op
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_val  input  32  multiplicand / dividend
rt_val  input  32  multiplier / divisor
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  32  MTHI/MTLO data
busy  output  1  operation in progress; CPU must stall MFHI/MFLO/new op
done  output  1  one-cycle pulse when hi/lo updated by an op
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (resetl high, async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts the op; hi/lo return to 0.
- All transitions occur on rising clk only when clk_enable=1.
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - latch op and operands.
  - For signed ops, take the magnitude of each operand and record neg_q = sign(rs)^sign(rt) and neg_r = sign(rs).
  - counter=0; go RUN.
  - For a divide with rt_val=0: go directly to FIX with div0 flag set.
- RUN: one iteration per cycle.
  - Multiply: 64-bit accumulator, shift-add on LSB of multiplier.
  - Divide: restoring shift-subtract; quotient bit = no-borrow.
  - At counter=31 go FIX, else counter+1.
- FIX, writes hi/lo, go IDLE, done=1 for that following cycle:
  - Multiply: {hi,lo} = product, negated (64-bit two's complement) if neg_q and signed.
  - Divide: lo = quotient, negated if neg_q; hi = remainder, negated if neg_r.
  - Div0: lo=DIV0_LO, hi=rs_val.
- Latency: start accepted at edge N → busy=1 from edge N through edge N+33 (33 cycles) → hi/lo valid and done=1 after edge N+33. Div0: busy 1 cycle, result after edge N+1.
- busy = (state != IDLE), registered.
- 0x8000_0000 DIV 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (natural wrap, no trap).
- Unsigned ops ignore operand signs; full 32-bit magnitudes, 64-bit product.
- start while busy: ignored (no re-latch, no restart).
- mthi/mtlo in IDLE: write on the edge; both may assert together.
- mthi/mtlo while busy: ignored.
- start together with mthi/mtlo in IDLE: start wins, the MT write is dropped.
- op values are sampled only at accepted start.

Optional Feature:
- MULDIV_FAST_MULT_EN defined:
  - MULT/MULTU skip RUN: IDLE→FIX using a single-cycle 64-bit signed/unsigned multiply of the latched operands.
  - Busy for 1 cycle; result after edge N+1.
  - Divides unchanged.
- Undefined: all multiplies take the 33-cycle iterative path. No multiplier operator is inferred.

Test Plan:
- Reset, then MULT rs=0xFFFF_FFFD(-3), rt=5 → busy 33 cycles; hi=0xFFFF_FFFF, lo=0xFFFF_FFF1, done one pulse.
- MULTU rs=0xFFFF_FFFF, rt=0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001. DIVU rs=100, rt=7 → lo=14, hi=2.
- DIV rs=0xFFFF_FFF9(-7), rt=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIV rs=0x8000_0000, rt=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIVU rs=0x1234, rt=0 → busy 1 cycle, lo=0xFFFF_FFFF, hi=0x1234. Repeat with MULDIV_FAST_MULT_EN: MULT 6×7 → lo=42 after 1 busy cycle.
- Cover ignored inputs and freeze:
  - start a DIV, then on cycle 5 pulse start (different operands) and mthi=1 wdata=0xAA → both ignored, original result appears.
  - Hold clk_enable=0 for 10 cycles mid-op → result delayed exactly 10 cycles.
- Cover mid-op reset and MT writes:
  - assert resetl on cycle 12 of a MULT → busy=0, hi=lo=0 immediately, no done.
  - Afterwards mthi=mtlo=1 wdata=0x55 → hi=lo=0x55.

Source files
------------

// File: rtl/mips_muldiv_ctrl.sv
// HI/LO sequencing controller for MULT/MULTU/DIV/DIVU/MTHI/MTLO: shift-add multiply,
// restoring divide, one bit per cycle. Define MULDIV_FAST_MULT_EN for single-cycle multiplies.
module mips_muldiv_ctrl #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetl,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MULDIV_FAST_MULT_EN
    localparam logic FAST_MULT = 1'b1;
`else
    localparam logic FAST_MULT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        if (sgn && v[31]) mag32 = ~v + 32'd1;
        else              mag32 = v;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
        if (en) cond_neg32 = ~v + 32'd1;
        else    cond_neg32 = v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic en);
        if (en) cond_neg64 = ~v + 64'd1;
        else    cond_neg64 = v;
    endfunction

    state_t      state_r, state_next_s;
    logic [4:0]  count_r;
    // acc_hi_r: partial product high half / remainder; acc_lo_r: multiplier / dividend->quotient
    logic [31:0] acc_hi_r, acc_lo_r, opnd_r;
    logic        is_div_r, div0_r, neg_q_r, neg_rem_r;
    logic        busy_r, done_r;
    logic [31:0] hi_r, lo_r;

    logic        sgn_s, div0_s;
    logic [32:0] mul_sum_s, div_shift_s;
    logic        div_ok_s;
    logic [31:0] rem_next_s;
    logic [63:0] product_s, signed_prod_s;

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Operand-dependent decode used when a start is accepted
    always_comb begin
        sgn_s  = ~op[0];
        div0_s = op[1] && (rt_val == 32'd0);
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (div0_s || (!op[1] && FAST_MULT)) state_next_s = FIX;
                    else                                 state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == 5'd31) state_next_s = FIX;
                else                  state_next_s = RUN;
            end
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Per-iteration arithmetic and the final product source
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : 33'd0);
        div_shift_s = {acc_hi_r, acc_lo_r[31]};
        div_ok_s    = (div_shift_s >= {1'b0, opnd_r});
        if (div_ok_s) rem_next_s = div_shift_s[31:0] - opnd_r;
        else          rem_next_s = div_shift_s[31:0];
`ifdef MULDIV_FAST_MULT_EN
        product_s = {32'd0, opnd_r} * {32'd0, acc_lo_r};
`else
        product_s = {acc_hi_r, acc_lo_r};
`endif
        signed_prod_s = cond_neg64(product_s, neg_q_r);
    end

    // State register
    always_ff @(posedge clk or posedge resetl) begin
        if (resetl)          state_r <= IDLE;
        else if (clk_enable) state_r <= state_next_s;
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clk or posedge resetl) begin
        if (resetl) begin
            count_r   <= 5'd0;
            acc_hi_r  <= 32'd0;
            acc_lo_r  <= 32'd0;
            opnd_r    <= 32'd0;
            is_div_r  <= 1'b0;
            div0_r    <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else if (clk_enable) begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_r == FIX);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        count_r   <= 5'd0;
                        acc_hi_r  <= 32'd0;
                        is_div_r  <= op[1];
                        div0_r    <= div0_s;
                        neg_q_r   <= sgn_s & (rs_val[31] ^ rt_val[31]);
                        neg_rem_r <= sgn_s & rs_val[31];
                        if (div0_s) begin
                            acc_lo_r <= rs_val;
                            opnd_r   <= rt_val;
                        end else if (op[1]) begin
                            acc_lo_r <= mag32(rs_val, sgn_s);
                            opnd_r   <= mag32(rt_val, sgn_s);
                        end else begin
                            acc_lo_r <= mag32(rt_val, sgn_s);
                            opnd_r   <= mag32(rs_val, sgn_s);
                        end
                    end else begin
                        if (mthi) hi_r <= wdata;
                        if (mtlo) lo_r <= wdata;
                    end
                end
                RUN: begin
                    count_r <= count_r + 5'd1;
                    if (is_div_r) begin
                        acc_hi_r <= rem_next_s;
                        acc_lo_r <= {acc_lo_r[30:0], div_ok_s};
                    end else begin
                        acc_hi_r <= mul_sum_s[32:1];
                        acc_lo_r <= {mul_sum_s[0], acc_lo_r[31:1]};
                    end
                end
                FIX: begin
                    if (div0_r) begin
                        hi_r <= acc_lo_r;
                        lo_r <= DIV0_LO;
                    end else if (is_div_r) begin
                        lo_r <= cond_neg32(acc_lo_r, neg_q_r);
                        hi_r <= cond_neg32(acc_hi_r, neg_rem_r);
                    end else begin
                        {hi_r, lo_r} <= signed_prod_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Directed self-checking bench for mips_muldiv_ctrl: arithmetic results, latency,
// ignored inputs, clock-enable freeze, mid-op reset and MTHI/MTLO writes.
module tb_mips_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        resetl = 1'b1;
    logic        clk_enable = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mips_muldiv_ctrl dut (
        .clk(clk), .resetl(resetl), .clk_enable(clk_enable), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Drive a one-cycle start; returns 1 time unit after the accepting edge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
    endtask

    // Count edges until busy drops (bounded)
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        resetl = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        @(negedge clk); resetl = 1'b0;
    endtask

    task automatic test_mult_signed;
        int n;
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy_start got=%b want=1", busy); end
        wait_idle(n);
        total++; if (n !== MUL_LAT) begin bad++; $display("FAIL mult_latency got=%0d want=%0d", n, MUL_LAT); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mult_done got=%b want=1", done); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo got=%h want=fffffff1", lo); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_multu;
        int n;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", hi); end
        total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", lo); end
        issue(2'b00, 32'd6, 32'd7);
        wait_idle(n);
        total++; if (n !== MUL_LAT) begin bad++; $display("FAIL mult67_latency got=%0d want=%0d", n, MUL_LAT); end
        total++; if (lo !== 32'd42) begin bad++; $display("FAIL mult67_lo got=%h want=2a", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL mult67_hi got=%h want=0", hi); end
    endtask

    task automatic test_divide;
        int n;
        issue(2'b11, 32'd100, 32'd7);
        wait_idle(n);
        total++; if (n !== 33) begin bad++; $display("FAIL divu_latency got=%0d want=33", n); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h want=e", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h want=2", hi); end
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo got=%h want=fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi got=%h want=ffffffff", hi); end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h want=80000000", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL div_ovf_hi got=%h want=0", hi); end
    endtask

    task automatic test_div0;
        int n;
        issue(2'b11, 32'h0000_1234, 32'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL div0_busy got=%b want=1", busy); end
        wait_idle(n);
        total++; if (n !== 1) begin bad++; $display("FAIL div0_latency got=%0d want=1", n); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL div0_done got=%b want=1", done); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo got=%h want=ffffffff", lo); end
        total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL div0_hi got=%h want=1234", hi); end
    endtask

    task automatic test_ignored;
        int n;
        issue(2'b10, 32'd1000, 32'd3);
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd5; mthi = 1'b1; wdata = 32'hAA;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
        total++; if (hi === 32'hAA) begin bad++; $display("FAIL busy_mthi got=%h want=not aa", hi); end
        wait_idle(n);
        total++; if (n + 5 !== 33) begin bad++; $display("FAIL ignored_latency got=%0d want=33", n + 5); end
        total++; if (lo !== 32'd333) begin bad++; $display("FAIL ignored_lo got=%h want=14d", lo); end
        total++; if (hi !== 32'd1) begin bad++; $display("FAIL ignored_hi got=%h want=1", hi); end
        // start and MT together in IDLE: start wins
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        wait_idle(n);
        total++; if (lo !== 32'd6) begin bad++; $display("FAIL start_wins_lo got=%h want=6", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL start_wins_hi got=%h want=0", hi); end
    endtask

    task automatic test_freeze;
        int n;
        issue(2'b11, 32'd100, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk); clk_enable = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL freeze_busy got=%b want=1", busy); end
        clk_enable = 1'b1;
        wait_idle(n);
        total++; if (n + 15 !== 43) begin bad++; $display("FAIL freeze_latency got=%0d want=43", n + 15); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL freeze_lo got=%h want=e", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL freeze_hi got=%h want=2", hi); end
    endtask

    task automatic test_reset_midop;
        int seen_done = 0;
        issue(2'b00, 32'd3, 32'd4);
        repeat (11) begin @(posedge clk); #1; end
        @(negedge clk); resetl = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL midrst_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL midrst_lo got=%h want=0", lo); end
        @(negedge clk); resetl = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        total++; if (seen_done !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", seen_done); end
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        total++; if (hi !== 32'h55) begin bad++; $display("FAIL mt_hi got=%h want=55", hi); end
        total++; if (lo !== 32'h55) begin bad++; $display("FAIL mt_lo got=%h want=55", lo); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mt_no_done got=%b want=0", done); end
    endtask

    initial begin
        test_reset;
        test_mult_signed;
        test_multu;
        test_divide;
        test_div0;
        test_ignored;
        test_freeze;
        test_reset_midop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
